// File: rtl/line_follow_pkg.sv
// Shared encodings for the line-follow motor controller.
//   state_e : controller state, also driven out on the 2-bit state port
//   DIR_*   : H-bridge direction bit values
//   side_e  : side of the bar on which the line was last seen
package line_follow_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_FOLLOW  = 2'd1,
      ST_SEARCH  = 2'd2,
      ST_STOPPED = 2'd3
   } state_e;

   localparam logic DIR_FWD = 1'b1;
   localparam logic DIR_REV = 1'b0;

   typedef enum logic {
      SIDE_LEFT  = 1'b0,
      SIDE_RIGHT = 1'b1
   } side_e;

endpackage

// File: rtl/line_follow_ctrl_pwm_gen.sv
// Single PWM channel.
//   clk, rst : clock, async active-high reset
//   duty     : requested duty; sampled only when the counter wraps
//   pwm      : high while the free-running counter is below the latched duty
module pwm_gen #(
   parameter int SPEED_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [SPEED_W-1:0] duty,
   output logic               pwm
);

   logic [SPEED_W-1:0] cnt_q;
   logic [SPEED_W-1:0] duty_q;

   // Duty is latched on the last count so a new value takes effect at the
   // start of a period and never truncates or stretches the current pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         duty_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
         if (&cnt_q) duty_q <= duty;
      end
   end

   // Purely combinational from registers, so reset drops it immediately.
   assign pwm = (cnt_q < duty_q);

endmodule

// File: rtl/line_follow_ctrl.sv
// Line-following motor controller.
//   clk, rst            : clock, async active-high reset
//   enable              : run request; low returns to IDLE on the next clock
//   sensors             : filtered sensor bar, 0 = line under sensor, MSB = left
//   pwm_out_l/r         : motor PWM pins
//   dir_l/r             : motor direction, 1 = forward
//   speed_l/r           : current registered duty per motor
//   state               : 0 IDLE, 1 FOLLOW, 2 SEARCH, 3 STOPPED
//   lost                : high while STOPPED (line search timed out)
module line_follow_ctrl
   import line_follow_pkg::*;
#(
   parameter int N_SENSORS    = 5,
   parameter int SPEED_W      = 8,
   parameter int STEP         = 32,
   parameter int SEARCH_SPD   = 96,
   parameter int TICK_DIV     = 4,
   parameter int LOST_TICKS   = 3,
   parameter int SEARCH_TICKS = 50
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic [N_SENSORS-1:0] sensors,
   output logic                 pwm_out_l,
   output logic                 pwm_out_r,
   output logic                 dir_l,
   output logic                 dir_r,
   output logic [SPEED_W-1:0]   speed_l,
   output logic [SPEED_W-1:0]   speed_r,
   output logic [1:0]           state,
   output logic                 lost
);

   localparam int MAX = (1 << SPEED_W) - 1;
   localparam int TW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int IW  = $clog2(N_SENSORS + 1);
   localparam int NLW = $clog2(LOST_TICKS + 1);
   localparam int SCW = $clog2(SEARCH_TICKS + 1);
   localparam logic [SPEED_W-1:0] SPD_MAX  = SPEED_W'(MAX);
   localparam logic [SPEED_W-1:0] SPD_SRCH = SPEED_W'(SEARCH_SPD);

   state_e             state_q, state_d;
   logic [SPEED_W-1:0] speed_l_q, speed_l_d, speed_r_q, speed_r_d;
   logic               dir_l_q, dir_l_d, dir_r_q, dir_r_d;
   logic [TW-1:0]      tick_q, tick_d;
   logic [NLW-1:0]     nl_q, nl_d, nl_inc;
   logic [SCW-1:0]     sc_q, sc_d, sc_inc;
   side_e              side_q, side_d;
   logic               tick;

   // ---------------- tick divider ----------------
   assign tick   = (tick_q == TW'(TICK_DIV - 1));
   assign tick_d = tick ? '0 : tick_q + 1'b1;
   assign nl_inc = nl_q + 1'b1;
   assign sc_inc = sc_q + 1'b1;

   // ---------------- position decode ----------------
   logic [N_SENSORS-1:0] det;
   logic [IW-1:0]        k, l_idx, r_idx;
   logic                 found;
   int                   err, mag, corr;
   logic [SPEED_W-1:0]   st_l, st_r;

   assign det = ~sensors;

   always_comb begin
      k     = '0;
      l_idx = '0;
      r_idx = '0;
      found = 1'b0;
      for (int i = 0; i < N_SENSORS; i++) begin
         if (det[i]) begin
            k     = k + 1'b1;
            l_idx = IW'(i);
            if (!found) r_idx = IW'(i);
            found = 1'b1;
         end
      end
   end

   // Positive err: line centroid left of centre, so slow the left wheel.
   always_comb begin
      err  = int'(l_idx) + int'(r_idx) - (N_SENSORS - 1);
      mag  = (err < 0) ? -err : err;
      corr = mag * STEP;
      if (corr > MAX) corr = MAX;
      st_l = SPD_MAX;
      st_r = SPD_MAX;
      // A full-bar crossbar reads as centred by geometry; drive straight.
      if (k != IW'(N_SENSORS)) begin
         if (err > 0)      st_l = SPEED_W'(MAX - corr);
         else if (err < 0) st_r = SPEED_W'(MAX - corr);
      end
   end

   // ---------------- state register ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         speed_l_q <= '0;
         speed_r_q <= '0;
         dir_l_q   <= DIR_FWD;
         dir_r_q   <= DIR_FWD;
         tick_q    <= '0;
         nl_q      <= '0;
         sc_q      <= '0;
         side_q    <= SIDE_LEFT;
      end else begin
         state_q   <= state_d;
         speed_l_q <= speed_l_d;
         speed_r_q <= speed_r_d;
         dir_l_q   <= dir_l_d;
         dir_r_q   <= dir_r_d;
         tick_q    <= tick_d;
         nl_q      <= nl_d;
         sc_q      <= sc_d;
         side_q    <= side_d;
      end
   end

   // ---------------- next state ----------------
   always_comb begin
      state_d = state_q;
      if (!enable) begin
         state_d = ST_IDLE;
      end else if (tick) begin
         case (state_q)
            ST_IDLE:    state_d = ST_FOLLOW;
            ST_FOLLOW:  if (k == '0 && nl_inc == NLW'(LOST_TICKS)) state_d = ST_SEARCH;
            // Detection is tested first so it wins over a coincident timeout.
            ST_SEARCH: begin
               if (k != '0)                          state_d = ST_FOLLOW;
               else if (sc_inc == SCW'(SEARCH_TICKS)) state_d = ST_STOPPED;
            end
            default:    state_d = state_q;
         endcase
      end
   end

   // ---------------- outputs / datapath ----------------
   always_comb begin
      speed_l_d = speed_l_q;
      speed_r_d = speed_r_q;
      dir_l_d   = dir_l_q;
      dir_r_d   = dir_r_q;
      nl_d      = nl_q;
      sc_d      = sc_q;
      side_d    = side_q;
      if (!enable) begin
         speed_l_d = '0;
         speed_r_d = '0;
         dir_l_d   = DIR_FWD;
         dir_r_d   = DIR_FWD;
         nl_d      = '0;
         sc_d      = '0;
      end else if (tick) begin
         if (k != '0 && err != 0) side_d = (err > 0) ? SIDE_LEFT : SIDE_RIGHT;
         case (state_q)
            ST_IDLE: begin
               speed_l_d = '0;
               speed_r_d = '0;
               dir_l_d   = DIR_FWD;
               dir_r_d   = DIR_FWD;
            end
            ST_FOLLOW: begin
               if (k == '0) begin
                  // No line: coast on the last command until the search kicks in.
                  if (nl_inc == NLW'(LOST_TICKS)) begin
                     nl_d      = '0;
                     speed_l_d = SPD_SRCH;
                     speed_r_d = SPD_SRCH;
                     dir_l_d   = (side_q == SIDE_LEFT) ? DIR_REV : DIR_FWD;
                     dir_r_d   = (side_q == SIDE_LEFT) ? DIR_FWD : DIR_REV;
                  end else begin
                     nl_d = nl_inc;
                  end
               end else begin
                  nl_d      = '0;
                  speed_l_d = st_l;
                  speed_r_d = st_r;
               end
            end
            ST_SEARCH: begin
               if (k != '0) begin
                  sc_d      = '0;
                  nl_d      = '0;
                  speed_l_d = st_l;
                  speed_r_d = st_r;
                  dir_l_d   = DIR_FWD;
                  dir_r_d   = DIR_FWD;
               end else if (sc_inc == SCW'(SEARCH_TICKS)) begin
                  sc_d      = '0;
                  speed_l_d = '0;
                  speed_r_d = '0;
                  dir_l_d   = DIR_FWD;
                  dir_r_d   = DIR_FWD;
               end else begin
                  sc_d = sc_inc;
               end
            end
            default: begin
               speed_l_d = '0;
               speed_r_d = '0;
               dir_l_d   = DIR_FWD;
               dir_r_d   = DIR_FWD;
            end
         endcase
      end
   end

   assign state   = state_q;
   assign lost    = (state_q == ST_STOPPED);
   assign speed_l = speed_l_q;
   assign speed_r = speed_r_q;
   assign dir_l   = dir_l_q;
   assign dir_r   = dir_r_q;

   pwm_gen #(.SPEED_W(SPEED_W)) u_pwm_l (
      .clk  (clk),
      .rst  (rst),
      .duty (speed_l_q),
      .pwm  (pwm_out_l)
   );

   pwm_gen #(.SPEED_W(SPEED_W)) u_pwm_r (
      .clk  (clk),
      .rst  (rst),
      .duty (speed_r_q),
      .pwm  (pwm_out_r)
   );

endmodule

// File: tb/tb_line_follow_ctrl.sv
// Bench for line_follow_ctrl: per-cycle comparison against a behavioural
// model, directed literal checks, randomized sensor/enable stimulus, and a
// standalone pwm_gen instance for duty-cycle and wrap-reload checks.
module tb_line_follow_ctrl;

   localparam int N    = 5;
   localparam int SW   = 8;
   localparam int STEP = 32;
   localparam int SPD  = 96;
   localparam int TD   = 4;
   localparam int LT   = 3;
   localparam int STK  = 50;
   localparam int MAX  = 255;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          enable = 1'b0;
   logic [N-1:0]  sensors = '1;
   logic          pwm_out_l, pwm_out_r, dir_l, dir_r, lost;
   logic [SW-1:0] speed_l, speed_r;
   logic [1:0]    state;
   logic [SW-1:0] pg_duty = '0;
   logic          pg_pwm;

   always #5 clk = ~clk;

   line_follow_ctrl #(
      .N_SENSORS(N), .SPEED_W(SW), .STEP(STEP), .SEARCH_SPD(SPD),
      .TICK_DIV(TD), .LOST_TICKS(LT), .SEARCH_TICKS(STK)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .sensors(sensors),
      .pwm_out_l(pwm_out_l), .pwm_out_r(pwm_out_r),
      .dir_l(dir_l), .dir_r(dir_r),
      .speed_l(speed_l), .speed_r(speed_r),
      .state(state), .lost(lost)
   );

   pwm_gen #(.SPEED_W(SW)) u_pg (.clk(clk), .rst(rst), .duty(pg_duty), .pwm(pg_pwm));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      int st; int sl; int sr; int dl; int dr; int nl; int sc; int left;
   } mdl_t;

   function automatic mdl_t step(mdl_t m, bit en, logic [N-1:0] s);
      mdl_t n;
      int k, hi, lo, e, c, sl_s, sr_s;
      n = m;
      if (!en) begin
         n.st = 0; n.sl = 0; n.sr = 0; n.dl = 1; n.dr = 1; n.nl = 0; n.sc = 0;
         return n;
      end
      k = 0; hi = -1; lo = N;
      for (int i = 0; i < N; i++)
         if (!s[i]) begin
            k++;
            if (i > hi) hi = i;
            if (i < lo) lo = i;
         end
      e = hi + lo - (N - 1);
      c = (e < 0 ? -e : e) * STEP;
      if (c > MAX) c = MAX;
      sl_s = (k == N || e <= 0) ? MAX : MAX - c;
      sr_s = (k == N || e >= 0) ? MAX : MAX - c;
      if (k > 0 && e != 0) n.left = (e > 0) ? 1 : 0;
      case (m.st)
         0: begin n.st = 1; n.sl = 0; n.sr = 0; n.dl = 1; n.dr = 1; end
         1: begin
            if (k == 0) begin
               n.nl = m.nl + 1;
               if (n.nl == LT) begin
                  n.st = 2; n.nl = 0; n.sl = SPD; n.sr = SPD;
                  n.dl = n.left ? 0 : 1; n.dr = n.left ? 1 : 0;
               end
            end else begin
               n.nl = 0; n.sl = sl_s; n.sr = sr_s;
            end
         end
         2: begin
            if (k > 0) begin
               n.st = 1; n.sc = 0; n.nl = 0; n.sl = sl_s; n.sr = sr_s; n.dl = 1; n.dr = 1;
            end else begin
               n.sc = m.sc + 1;
               if (n.sc == STK) begin
                  n.st = 3; n.sc = 0; n.sl = 0; n.sr = 0; n.dl = 1; n.dr = 1;
               end
            end
         end
         default: begin n.sl = 0; n.sr = 0; n.dl = 1; n.dr = 1; end
      endcase
      return n;
   endfunction

   function automatic mdl_t mdl_reset();
      mdl_t r;
      r.st = 0; r.sl = 0; r.sr = 0; r.dl = 1; r.dr = 1; r.nl = 0; r.sc = 0; r.left = 1;
      return r;
   endfunction

   mdl_t m;
   int   mt, pc, pdl, pdr;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m <= mdl_reset(); mt <= 0; pc <= 0; pdl <= 0; pdr <= 0;
      end else begin
         if (!enable || mt == TD - 1) m <= step(m, enable, sensors);
         mt <= (mt == TD - 1) ? 0 : mt + 1;
         pc <= (pc == MAX) ? 0 : pc + 1;
         if (pc == MAX) begin pdl <= m.sl; pdr <= m.sr; end
      end
   end

   bit mon_en = 1'b0;
   always @(negedge clk) begin
      if (mon_en && !rst) begin
         chk("m_state", int'(state),   m.st);
         chk("m_spd_l", int'(speed_l), m.sl);
         chk("m_spd_r", int'(speed_r), m.sr);
         chk("m_dir_l", int'(dir_l),   m.dl);
         chk("m_dir_r", int'(dir_r),   m.dr);
         chk("m_lost",  int'(lost),    (m.st == 3) ? 1 : 0);
         chk("m_pwm_l", int'(pwm_out_l), (pc < pdl) ? 1 : 0);
         chk("m_pwm_r", int'(pwm_out_r), (pc < pdr) ? 1 : 0);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic drive(input bit en, input logic [N-1:0] s);
      @(negedge clk); #2;
      enable = en; sensors = s;
   endtask

   task automatic settle(input int cyc);
      repeat (cyc) @(negedge clk);
      #1;
   endtask

   task automatic pg_count(input int n, output int highs);
      highs = 0;
      repeat (n) begin
         @(negedge clk);
         if (pg_pwm) highs++;
      end
   endtask

   int  h;
   bit  prev, seen;

   initial begin
      #1 rst = 1'b1;
      #1;
      chk("rst_state", int'(state), 0);
      chk("rst_spd_l", int'(speed_l), 0);
      chk("rst_spd_r", int'(speed_r), 0);
      chk("rst_dir",   int'({dir_l, dir_r}), 3);
      chk("rst_lost",  int'(lost), 0);
      chk("rst_pwm",   int'({pwm_out_l, pwm_out_r}), 0);
      #10 rst = 1'b0;
      mon_en = 1'b1;

      drive(1'b1, 5'b11011); settle(12);
      chk("ctr_state", int'(state), 1);
      chk("ctr_spd_l", int'(speed_l), 255);
      chk("ctr_spd_r", int'(speed_r), 255);

      drive(1'b1, 5'b01111); settle(8);
      chk("lft_spd_l", int'(speed_l), 127);
      chk("lft_spd_r", int'(speed_r), 255);

      drive(1'b1, 5'b11110); settle(8);
      chk("rgt_spd_l", int'(speed_l), 255);
      chk("rgt_spd_r", int'(speed_r), 127);

      drive(1'b1, 5'b11001); settle(8);
      chk("m1_spd_l", int'(speed_l), 255);
      chk("m1_spd_r", int'(speed_r), 223);

      drive(1'b1, 5'b00000); settle(8);
      chk("x_spd", int'({speed_l, speed_r}), 16'hFFFF);
      chk("x_state", int'(state), 1);

      drive(1'b1, 5'b01111); settle(8);
      drive(1'b1, 5'b11111); settle(16);
      chk("srch_state", int'(state), 2);
      chk("srch_dir",   int'({dir_l, dir_r}), 1);
      chk("srch_spd_l", int'(speed_l), 96);
      chk("srch_spd_r", int'(speed_r), 96);

      settle(220);
      chk("stop_state", int'(state), 3);
      chk("stop_lost",  int'(lost), 1);
      chk("stop_spd",   int'({speed_l, speed_r}), 0);

      drive(1'b0, 5'b11111);
      @(negedge clk); #1;
      chk("dis_state", int'(state), 0);
      chk("dis_lost",  int'(lost), 0);

      drive(1'b1, 5'b11110); settle(20);
      drive(1'b1, 5'b11111); settle(16);
      chk("srch_r_state", int'(state), 2);
      chk("srch_r_dir",   int'({dir_l, dir_r}), 2);

      @(negedge clk); #2;
      rst = 1'b1;
      #1;
      chk("arst_state", int'(state), 0);
      chk("arst_spd",   int'({speed_l, speed_r}), 0);
      chk("arst_pwm",   int'({pwm_out_l, pwm_out_r}), 0);
      chk("arst_dir",   int'({dir_l, dir_r}), 3);
      settle(2);
      #1 rst = 1'b0;

      // Randomized traffic; occasional long blank stretches reach SEARCH/STOPPED.
      for (int it = 0; it < 400; it++) begin
         logic [N-1:0] s;
         bit en;
         en = ($urandom_range(0, 99) >= 3);
         s  = ($urandom_range(0, 99) < 45) ? 5'b11111 : N'($urandom);
         drive(en, s);
         if ($urandom_range(0, 99) < 6) begin
            sensors = 5'b11111;
            repeat ($urandom_range(10, 250)) @(negedge clk);
         end else begin
            repeat ($urandom_range(1, 8)) @(negedge clk);
         end
      end
      mon_en = 1'b0;

      // Standalone PWM: duty count, zero duty, and reload only at wrap.
      @(negedge clk); #2 pg_duty = 8'd64;
      repeat (600) @(negedge clk);
      pg_count(256, h);
      chk("pwm64_highs", h, 64);

      @(negedge clk); #2 pg_duty = 8'd0;
      repeat (600) @(negedge clk);
      pg_count(256, h);
      chk("pwm0_highs", h, 0);

      @(negedge clk); #2 pg_duty = 8'd64;
      repeat (600) @(negedge clk);
      prev = 1'b1; seen = 1'b0;
      for (int i = 0; i < 600 && !seen; i++) begin
         @(negedge clk);
         if (pg_pwm && !prev) seen = 1'b1;
         prev = pg_pwm;
      end
      chk("pwm_rise_found", int'(seen), 1);
      #2 pg_duty = 8'd200;
      pg_count(255, h);
      chk("pwm_midper_highs", h, 63);
      pg_count(256, h);
      chk("pwm_newper_highs", h, 200);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
